shift_register_unit: RTL and testbench
======================================

# shift_register_unit

Parametrised successor to the team's 8-bit board register. Combines a tick-rate clock divider with a WIDTH-bit shift/parallel register that supports four transfer modes: PIPO, PISO, SIPO and SISO. PISO and SIPO run as framed transfers with a start/busy/done handshake. Sits between board switches/LEDs and the serial link, driven by the single board clock.

## Interface
Parameters:
- WIDTH, 8, register width in bits (≥2)
- DIV, 100000000, clock cycles per tick (≥2)
- LSB_FIRST, 1, 1 = shift right (bit 0 out first), 0 = shift left (bit WIDTH-1 out first)

Ports:
- clkIn  input  1  board clock; all logic on rising edge
- rstnIn  input  1  reset, synchronous, active-low
- clkOut  output  1  divided clock; toggles on every tick
- mode  input  2  00 PIPO, 01 PISO, 10 SIPO, 11 SISO; sampled only in IDLE
- start  input  1  one-cycle strobe; begins a PISO/SIPO frame
- regIn  input  WIDTH  parallel data in
- bitIn  input  1  serial data in
- regOut  output  WIDTH  parallel data out
- bitOut  output  1  serial data out
- busy  output  1  high while a frame is in progress
- done  output  1  one-cycle pulse at frame end

## Operation
- Divider: cnt runs 0..DIV-1. tick = 1 for the single cycle with cnt == DIV-1; cnt then wraps to 0 and clkOut inverts.
- Shifter sh is WIDTH bits. A shift by one is defined as follows:
  - LSB_FIRST=1: sh <= {serial_in, sh[WIDTH-1:1]}.
  - LSB_FIRST=0: sh <= {sh[WIDTH-2:0], serial_in}.
  - serial_in is bitIn in SIPO/SISO and 0 in PISO.
- bitOut = sh[0] when LSB_FIRST=1, else sh[WIDTH-1].
- FSM has two states, IDLE and RUN. Only PISO and SIPO enter RUN.
- IDLE, mode PIPO: on tick, regOut <= regIn. sh is not touched.
- IDLE, mode SISO: on tick, shift sh. regOut holds.
- IDLE, mode PISO, start=1: sh <= regIn, bitCnt <= 0, go to RUN.
- IDLE, mode SIPO, start=1: bitCnt <= 0, go to RUN.
- IDLE, start while mode is PIPO or SISO: ignored.
- RUN: on each tick, shift sh and bitCnt++.
  - When the tick takes bitCnt to WIDTH: go to IDLE and pulse done.
  - SIPO only, on that same tick: regOut <= the post-shift sh value.
- busy = (state == RUN).
- In RUN, mode and start are ignored. A mode change takes effect at the next IDLE cycle.
- bitCnt width is clog2(WIDTH+1).

## Timing
- Reset, synchronous, when rstnIn=0 at a clock edge:
  - cnt=0, clkOut=0, sh=0, regOut=0, bitOut=0, busy=0, done=0, state IDLE, bitCnt=0.
  - Reset mid-frame aborts with no done pulse.
- Tick spacing is exactly DIV cycles. The first tick after reset release occurs DIV cycles later.
- PISO latency:
  - bitOut shows the first bit in the cycle after start.
  - Each subsequent bit appears the cycle after each tick.
  - done and busy falling happen in the cycle after the WIDTH-th tick. The frame spans WIDTH ticks.
- start in the same cycle as a tick: start wins. The load happens, no shift that cycle, and that tick is not counted.
- SIPO: bitIn is sampled at each tick edge. regOut updates in the same cycle as done.
- done is high for exactly one cycle. busy drops in the same cycle done rises.
- A start that arrives while done is high (state is IDLE) is accepted, allowing back-to-back frames.

## Structure
- Shared package shift_register_pkg holds:
  - the mode encodings MODE_PIPO, MODE_PISO, MODE_SIPO, MODE_SISO;
  - the state encoding ST_IDLE, ST_RUN.
- Sub-module tick_divider (parameter DIV; ports clkIn, rstnIn, tick, clkOut) contains the counter and clkOut toggle. It is reusable by other board blocks.
- The top contains the FSM, bit counter, shifter and regOut.

## Test plan
All scenarios use WIDTH=8, DIV=4, LSB_FIRST=1 unless noted.
- Reset and divider:
  - Hold rstnIn=0 for 3 cycles, then release.
  - All outputs must be 0.
  - tick every 4 cycles; clkOut period 8 cycles.
- PIPO: regIn=8'hA5 in mode 00.
  - regOut=8'hA5 after the first tick, not before.
  - regIn changed to 8'h3C is reflected only at the next tick.
- PISO: regIn=8'hB2, pulse start.
  - busy=1 next cycle.
  - bitOut sequence 0,1,0,0,1,1,0,1 across ticks.
  - done pulses once after the 8th tick; bitOut=0 afterwards.
- SIPO: pulse start, drive bitIn=1,1,0,0,1,0,1,0 at successive ticks.
  - regOut=8'h53 in the same cycle done pulses.
  - regOut stays 0 before that.
- Boundary, PISO frame:
  - start coincident with a tick: the frame still takes 8 further ticks.
  - mode changed to PIPO mid-frame: ignored.
  - start held during RUN: ignored.
  - rstnIn=0 at bit 4: no done, busy=0, regOut=0.
- Back-to-back PISO with LSB_FIRST=0:
  - Second start during the done cycle is accepted.
  - First frame 8'h81 gives bitOut 1,0,0,0,0,0,0,1, MSB first.

Source files
------------

// File: rtl/shift_register_pkg.sv
// Shared encodings for the shift register unit: transfer modes and FSM states.
package shift_register_pkg;

  typedef enum logic [1:0] {
    MODE_PIPO = 2'b00,
    MODE_PISO = 2'b01,
    MODE_SIPO = 2'b10,
    MODE_SISO = 2'b11
  } RegMode;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } UnitState;

endpackage

// File: rtl/shift_register_tick_divider.sv
// Tick-rate divider: one-cycle tick every DIV board clocks, and a divided
// clock that inverts on each tick. Kept standalone so other board blocks can reuse it.
module tick_divider #(
  parameter int DIV = 100000000
) (
  input  logic clkIn,
  input  logic rstnIn,
  output logic tick,
  output logic clkOut
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_MAX);

  // Free-running counter; wraps on the tick cycle and flips the divided clock.
  always_ff @(posedge clkIn) begin
    if (!rstnIn) begin
      cnt    <= '0;
      clkOut <= 1'b0;
    end else if (tick) begin
      cnt    <= '0;
      clkOut <= ~clkOut;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shift_register_unit.sv
// Parametrised board register: PIPO/SISO act on divider ticks while idle,
// PISO/SIPO run as framed transfers with a start/busy/done handshake.
module shift_register_unit
  import shift_register_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 100000000,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clkIn,
  input  logic             rstnIn,
  output logic             clkOut,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [WIDTH-1:0] regIn,
  input  logic             bitIn,
  output logic [WIDTH-1:0] regOut,
  output logic             bitOut,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  UnitState         state, stateNext;
  RegMode           modeSel;
  logic             tick;
  logic             serialIn;
  logic             frameSipo, frameSipoNext;
  logic             doneNext;
  logic [CNT_W-1:0] bitCnt, bitCntNext;
  logic [WIDTH-1:0] sh, shNext, shShifted, regOutNext;

  tick_divider #(.DIV(DIV)) uDivider (
    .clkIn  (clkIn),
    .rstnIn (rstnIn),
    .tick   (tick),
    .clkOut (clkOut)
  );

  assign modeSel = RegMode'(mode);
  assign busy    = (state == ST_RUN);
  assign bitOut  = LSB_FIRST ? sh[0] : sh[WIDTH-1];

  // Serial feed: bitIn for SIPO frames and idle SISO, zeros behind a PISO frame.
  always_comb begin
    serialIn = 1'b0;
    if (state == ST_RUN) begin
      serialIn = frameSipo ? bitIn : 1'b0;
    end else if (modeSel == MODE_SISO) begin
      serialIn = bitIn;
    end
  end

  // One-position shift in the configured direction.
  always_comb begin
    shShifted = sh;
    if (LSB_FIRST) begin
      shShifted = {serialIn, sh[WIDTH-1:1]};
    end else begin
      shShifted = {sh[WIDTH-2:0], serialIn};
    end
  end

  // Next-state and datapath: a start in IDLE beats a coincident tick, and the
  // frame mode is captured at start so mode changes during RUN are ignored.
  always_comb begin
    stateNext     = state;
    shNext        = sh;
    bitCntNext    = bitCnt;
    regOutNext    = regOut;
    frameSipoNext = frameSipo;
    doneNext      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && (modeSel == MODE_PISO)) begin
          shNext        = regIn;
          bitCntNext    = '0;
          frameSipoNext = 1'b0;
          stateNext     = ST_RUN;
        end else if (start && (modeSel == MODE_SIPO)) begin
          bitCntNext    = '0;
          frameSipoNext = 1'b1;
          stateNext     = ST_RUN;
        end else if (tick) begin
          if (modeSel == MODE_PIPO) begin
            regOutNext = regIn;
          end else if (modeSel == MODE_SISO) begin
            shNext = shShifted;
          end
        end
      end
      ST_RUN: begin
        if (tick) begin
          shNext     = shShifted;
          bitCntNext = bitCnt + 1'b1;
          if (bitCnt == LAST_BIT) begin
            stateNext = ST_IDLE;
            doneNext  = 1'b1;
            if (frameSipo) begin
              regOutNext = shShifted;
            end
          end
        end
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame without a done pulse.
  always_ff @(posedge clkIn) begin
    if (!rstnIn) begin
      state     <= ST_IDLE;
      sh        <= '0;
      bitCnt    <= '0;
      regOut    <= '0;
      frameSipo <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= stateNext;
      sh        <= shNext;
      bitCnt    <= bitCntNext;
      regOut    <= regOutNext;
      frameSipo <= frameSipoNext;
      done      <= doneNext;
    end
  end

endmodule

// File: tb/tb_shift_register_unit.sv
// Directed bench for shift_register_unit: unit A is LSB-first, unit B MSB-first.
module tb_shift_register_unit;
  import shift_register_pkg::*;

  localparam int WIDTH = 8;
  localparam int DIV   = 4;

  logic       clkIn = 1'b0;
  logic       rstnIn = 1'b0;

  logic [1:0] modeA = MODE_PIPO;
  logic       startA = 1'b0;
  logic [7:0] regInA = 8'h00;
  logic       bitInA = 1'b0;
  logic [7:0] regOutA;
  logic       bitOutA, busyA, doneA, clkOutA;

  logic [1:0] modeB = MODE_PIPO;
  logic       startB = 1'b0;
  logic [7:0] regInB = 8'h00;
  logic       bitInB = 1'b0;
  logic [7:0] regOutB;
  logic       bitOutB, busyB, doneB, clkOutB;

  int checkCount = 0;
  int errorCount = 0;
  int tbCycle = 0;

  logic [7:0] pat;

  shift_register_unit #(.WIDTH(WIDTH), .DIV(DIV), .LSB_FIRST(1'b1)) dutA (
    .clkIn(clkIn), .rstnIn(rstnIn), .clkOut(clkOutA), .mode(modeA), .start(startA),
    .regIn(regInA), .bitIn(bitInA), .regOut(regOutA), .bitOut(bitOutA),
    .busy(busyA), .done(doneA)
  );

  shift_register_unit #(.WIDTH(WIDTH), .DIV(DIV), .LSB_FIRST(1'b0)) dutB (
    .clkIn(clkIn), .rstnIn(rstnIn), .clkOut(clkOutB), .mode(modeB), .start(startB),
    .regIn(regInB), .bitIn(bitInB), .regOut(regOutB), .bitOut(bitOutB),
    .busy(busyB), .done(doneB)
  );

  always #5 clkIn = ~clkIn;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic s, input logic [7:0] r, input logic b);
    modeA  = m;
    startA = s;
    regInA = r;
    bitInA = b;
  endtask

  task automatic stepCycle();
    @(posedge clkIn);
    if (rstnIn) tbCycle++;
    else tbCycle = 0;
    #1;
  endtask

  task automatic waitTick(input string tag);
    for (int i = 0; i < 2 * DIV; i++) begin
      stepCycle();
      if (tbCycle % DIV == 0) return;
    end
    errorCount++;
    $display("[TB] FAIL %s: no tick within %0d cycles", tag, 2 * DIV);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with PIPO data already present
    applyStimulus(MODE_PIPO, 1'b0, 8'hA5, 1'b0);
    rstnIn = 1'b0;
    repeat (3) stepCycle();
    checkOutput("rstRegOutA", regOutA, 8'h00);
    checkOutput("rstBitOutA", bitOutA, 1'b0);
    checkOutput("rstBusyA", busyA, 1'b0);
    checkOutput("rstDoneA", doneA, 1'b0);
    checkOutput("rstClkOutA", clkOutA, 1'b0);
    checkOutput("rstRegOutB", regOutB, 8'h00);
    checkOutput("rstBitOutB", bitOutB, 1'b0);
    rstnIn = 1'b1;

    // Divider period and PIPO loading on ticks only
    for (int k = 1; k <= 16; k++) begin
      stepCycle();
      checkOutput($sformatf("clkOutA_c%0d", k), clkOutA, (k / 4) % 2);
      checkOutput($sformatf("clkOutB_c%0d", k), clkOutB, (k / 4) % 2);
      checkOutput($sformatf("pipoRegOut_c%0d", k), regOutA,
                  (k < 4) ? 8'h00 : ((k < 8) ? 8'hA5 : 8'h3C));
      if (k == 5) applyStimulus(MODE_PIPO, 1'b0, 8'h3C, 1'b0);
    end

    // PISO frame of 8'hB2, LSB first
    pat = 8'hB2;
    applyStimulus(MODE_PISO, 1'b1, pat, 1'b0);
    stepCycle();
    applyStimulus(MODE_PISO, 1'b0, pat, 1'b0);
    checkOutput("pisoBusy", busyA, 1'b1);
    checkOutput("pisoBit0", bitOutA, pat[0]);
    for (int i = 1; i < 8; i++) begin
      waitTick("pisoTick");
      checkOutput($sformatf("pisoBit%0d", i), bitOutA, pat[i]);
      checkOutput($sformatf("pisoBusy%0d", i), busyA, 1'b1);
      checkOutput($sformatf("pisoDoneLow%0d", i), doneA, 1'b0);
    end
    waitTick("pisoLastTick");
    checkOutput("pisoDone", doneA, 1'b1);
    checkOutput("pisoBusyDrop", busyA, 1'b0);
    checkOutput("pisoBitAfter", bitOutA, 1'b0);
    checkOutput("pisoRegOutHeld", regOutA, 8'h3C);
    stepCycle();
    checkOutput("pisoDoneOnce", doneA, 1'b0);

    // SIPO frame after a fresh reset: bits 1,1,0,0,1,0,1,0 give 8'h53
    rstnIn = 1'b0;
    repeat (3) stepCycle();
    rstnIn = 1'b1;
    pat = 8'h53;
    applyStimulus(MODE_SIPO, 1'b1, 8'h00, 1'b0);
    stepCycle();
    checkOutput("sipoBusy", busyA, 1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(MODE_SIPO, 1'b0, 8'h00, pat[i]);
      waitTick("sipoTick");
      if (i < 7) begin
        checkOutput($sformatf("sipoRegOutZero%0d", i), regOutA, 8'h00);
        checkOutput($sformatf("sipoDoneLow%0d", i), doneA, 1'b0);
      end else begin
        checkOutput("sipoRegOut", regOutA, 8'h53);
        checkOutput("sipoDone", doneA, 1'b1);
        checkOutput("sipoBusyDrop", busyA, 1'b0);
      end
    end

    // PISO start coincident with a tick, mode change and held start mid-frame
    for (int i = 0; i < 2 * DIV && (tbCycle % DIV) != DIV - 1; i++) stepCycle();
    pat = 8'hB2;
    applyStimulus(MODE_PISO, 1'b1, pat, 1'b0);
    stepCycle();
    applyStimulus(MODE_PIPO, 1'b1, 8'hFF, 1'b0);
    checkOutput("coinBusy", busyA, 1'b1);
    checkOutput("coinBit0", bitOutA, pat[0]);
    for (int i = 1; i < 8; i++) begin
      waitTick("coinTick");
      checkOutput($sformatf("coinBit%0d", i), bitOutA, pat[i]);
      checkOutput($sformatf("coinBusy%0d", i), busyA, 1'b1);
      checkOutput($sformatf("coinRegOut%0d", i), regOutA, 8'h53);
    end
    waitTick("coinLastTick");
    checkOutput("coinDone", doneA, 1'b1);
    checkOutput("coinRegOutHeld", regOutA, 8'h53);
    applyStimulus(MODE_PISO, 1'b0, pat, 1'b0);

    // Reset in the middle of a PISO frame
    stepCycle();
    applyStimulus(MODE_PISO, 1'b1, pat, 1'b0);
    stepCycle();
    applyStimulus(MODE_PISO, 1'b0, pat, 1'b0);
    repeat (4) waitTick("abortTick");
    checkOutput("abortBusyBefore", busyA, 1'b1);
    rstnIn = 1'b0;
    stepCycle();
    checkOutput("abortBusy", busyA, 1'b0);
    checkOutput("abortDone", doneA, 1'b0);
    checkOutput("abortRegOut", regOutA, 8'h00);
    checkOutput("abortBitOut", bitOutA, 1'b0);
    stepCycle();
    rstnIn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      checkOutput($sformatf("abortNoDone%0d", i), doneA, 1'b0);
      checkOutput($sformatf("abortIdle%0d", i), busyA, 1'b0);
    end
    applyStimulus(MODE_PIPO, 1'b0, 8'h00, 1'b0);

    // Back-to-back PISO frames MSB first on unit B
    pat = 8'h81;
    modeB = MODE_PISO;
    regInB = pat;
    startB = 1'b1;
    stepCycle();
    startB = 1'b0;
    checkOutput("b2bBusy", busyB, 1'b1);
    checkOutput("b2bBit7", bitOutB, pat[7]);
    for (int i = 6; i >= 0; i--) begin
      waitTick("b2bTick");
      checkOutput($sformatf("b2bBit%0d", i), bitOutB, pat[i]);
    end
    waitTick("b2bLastTick");
    checkOutput("b2bDone", doneB, 1'b1);
    checkOutput("b2bBusyDrop", busyB, 1'b0);
    pat = 8'hC3;
    regInB = pat;
    startB = 1'b1;
    stepCycle();
    startB = 1'b0;
    checkOutput("b2bSecondBusy", busyB, 1'b1);
    checkOutput("b2bSecondDoneLow", doneB, 1'b0);
    checkOutput("b2bSecondBit7", bitOutB, pat[7]);
    waitTick("b2bSecondTick");
    checkOutput("b2bSecondBit6", bitOutB, pat[6]);
    waitTick("b2bSecondTick");
    checkOutput("b2bSecondBit5", bitOutB, pat[5]);
    repeat (5) waitTick("b2bSecondTick");
    checkOutput("b2bSecondBusyLate", busyB, 1'b1);
    waitTick("b2bSecondLastTick");
    checkOutput("b2bSecondDone", doneB, 1'b1);
    checkOutput("b2bSecondBitAfter", bitOutB, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
